// File: rtl/proximity_pkg.sv
// Shared types, default 50 MHz timing constants and helpers for the
// ultrasonic proximity array.
package proximity_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_RESULT,
    ST_GAP
  } prox_state_t;

  localparam int DEF_CYCLES_PER_MM = 291;
  localparam int DEF_TRIG_CYCLES   = 500;
  localparam int DEF_WAIT_CYCLES   = 50_000;
  localparam int DEF_GAP_CYCLES    = 3_000_000;
  localparam int DEF_THRESH_MM     = 1000;
  localparam int DEF_HYST_MM       = 50;
  localparam int DEF_DEBOUNCE      = 2;

  // All-ones distance code, used as the "no reading" marker.
  function automatic int DIST_MAX(input int dist_w);
    return (1 << dist_w) - 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/proximity_filter.sv
// One channel's obstacle flag: debounced near/far decision with a
// hysteresis band above the threshold.
module proximity_filter
  import proximity_pkg::*;
#(
  parameter int DIST_W    = 12,
  parameter int THRESH_MM = DEF_THRESH_MM,
  parameter int HYST_MM   = DEF_HYST_MM,
  parameter int DEBOUNCE  = DEF_DEBOUNCE
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              valid,
  input  logic              timeout,
  input  logic [DIST_W-1:0] distance,
  output logic              stop
);

  localparam int            CW       = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DEB      = CW'(DEBOUNCE);
  localparam logic [31:0]   NEAR_LIM = 32'(THRESH_MM);
  localparam logic [31:0]   FAR_LIM  = 32'(THRESH_MM + HYST_MM);

  logic [31:0]   dist_ext;
  logic          is_near;
  logic          is_far;
  logic [CW-1:0] near_cnt;
  logic [CW-1:0] far_cnt;
  logic [CW-1:0] near_inc;
  logic [CW-1:0] far_inc;

  // A timeout never counts as near; it always counts as far.
  assign dist_ext = 32'(distance);
  assign is_near  = !timeout && (dist_ext < NEAR_LIM);
  assign is_far   = timeout || (dist_ext >= FAR_LIM);
  assign near_inc = (near_cnt == DEB) ? DEB : near_cnt + 1'b1;
  assign far_inc  = (far_cnt == DEB) ? DEB : far_cnt + 1'b1;

  // Update the debounce counters and the flag once per published result.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      near_cnt <= '0;
      far_cnt  <= '0;
      stop     <= 1'b0;
    end else if (valid) begin
      if (is_near) begin
        far_cnt  <= '0;
        near_cnt <= near_inc;
        if (near_inc == DEB) stop <= 1'b1;
      end else if (is_far) begin
        near_cnt <= '0;
        far_cnt  <= far_inc;
        if (far_inc == DEB) stop <= 1'b0;
      end else begin
        near_cnt <= '0;
        far_cnt  <= '0;
      end
    end
  end

endmodule

// File: rtl/proximity_array.sv
// Round-robin sonar scheduler: one sensor pings at a time, echo width is
// timed on CLOCK_50 and converted to mm, each channel feeds a stop filter.
//
// state        | meaning
// ST_IDLE      | waiting for enable to start the current channel
// ST_TRIG      | trigger pulse on the active channel
// ST_WAIT_RISE | waiting for a fresh echo rising edge (bounded)
// ST_MEASURE   | timing echo high; prescaler + mm counter running
// ST_RESULT    | result published this cycle
// ST_GAP       | settle time, then advance to the next channel
module proximity_array
  import proximity_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int DIST_W        = 12,
  parameter int CYCLES_PER_MM = DEF_CYCLES_PER_MM,
  parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
  parameter int WAIT_CYCLES   = DEF_WAIT_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int THRESH_MM     = DEF_THRESH_MM,
  parameter int HYST_MM       = DEF_HYST_MM,
  parameter int DEBOUNCE      = DEF_DEBOUNCE
) (
  input  logic                                        CLOCK_50,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic [NUM_CH-1:0]                           echo,
  output logic [NUM_CH-1:0]                           trig,
  output logic [NUM_CH*DIST_W-1:0]                    distance_mm,
  output logic [NUM_CH-1:0]                           valid,
  output logic [NUM_CH-1:0]                           timeout,
  output logic [NUM_CH-1:0]                           stop,
  output logic                                        any_stop,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] active_ch
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TW   = $clog2(max3(TRIG_CYCLES, WAIT_CYCLES, GAP_CYCLES) + 1);
  localparam int PW   = (CYCLES_PER_MM > 1) ? $clog2(CYCLES_PER_MM) : 1;

  localparam logic [TW-1:0]     TRIG_LD  = TW'(TRIG_CYCLES - 1);
  localparam logic [TW-1:0]     WAIT_LD  = TW'(WAIT_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0]     PSC_LAST = PW'(CYCLES_PER_MM - 1);
  localparam logic [DIST_W-1:0] D_MAX    = DIST_W'(DIST_MAX(DIST_W));
  localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(NUM_CH - 1);

  prox_state_t       state;
  logic [TW-1:0]     timer;
  logic [PW-1:0]     psc;
  logic [DIST_W-1:0] mm;
  logic [DIST_W-1:0] mm_nxt;
  logic              psc_wrap;
  logic [NUM_CH-1:0] echo_s1;
  logic [NUM_CH-1:0] echo_s2;
  logic [NUM_CH-1:0] echo_prev;
  logic              rise;
  logic              fall;

  // Two-stage synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      echo_s1   <= '0;
      echo_s2   <= '0;
      echo_prev <= '0;
    end else begin
      echo_s1   <= echo;
      echo_s2   <= echo_s1;
      echo_prev <= echo_s2;
    end
  end

  assign rise = echo_s2[active_ch] & ~echo_prev[active_ch];
  assign fall = ~echo_s2[active_ch] & echo_prev[active_ch];

  // Every MEASURE cycle (fall cycle included) is one cycle of echo high,
  // so the count equals the synchronised high time H.
  assign psc_wrap = (psc == PSC_LAST);
  assign mm_nxt   = psc_wrap ? mm + 1'b1 : mm;

  // Scheduler: trigger, echo timing, result publication and settle gap.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      active_ch   <= '0;
      timer       <= '0;
      psc         <= '0;
      mm          <= '0;
      trig        <= '0;
      valid       <= '0;
      timeout     <= '0;
      distance_mm <= '0;
    end else begin
      valid   <= '0;
      timeout <= '0;
      unique case (state)
        ST_IDLE: begin
          if (enable) begin
            state           <= ST_TRIG;
            trig[active_ch] <= 1'b1;
            timer           <= TRIG_LD;
          end
        end
        ST_TRIG: begin
          if (timer == '0) begin
            trig  <= '0;
            state <= ST_WAIT_RISE;
            timer <= WAIT_LD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_WAIT_RISE: begin
          if (rise) begin
            state <= ST_MEASURE;
            psc   <= '0;
            mm    <= '0;
          end else if (timer == '0) begin
            distance_mm[active_ch*DIST_W +: DIST_W] <= D_MAX;
            valid[active_ch]   <= 1'b1;
            timeout[active_ch] <= 1'b1;
            state              <= ST_RESULT;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_MEASURE: begin
          psc <= psc_wrap ? '0 : psc + 1'b1;
          mm  <= mm_nxt;
          if (fall || (mm_nxt == D_MAX)) begin
            distance_mm[active_ch*DIST_W +: DIST_W] <= mm_nxt;
            valid[active_ch] <= 1'b1;
            state            <= ST_RESULT;
          end
        end
        ST_RESULT: begin
          state <= ST_GAP;
          timer <= GAP_LD;
        end
        ST_GAP: begin
          if (timer == '0) begin
            state     <= ST_IDLE;
            active_ch <= (active_ch == CH_LAST) ? '0 : active_ch + 1'b1;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_filt
      proximity_filter #(
        .DIST_W   (DIST_W),
        .THRESH_MM(THRESH_MM),
        .HYST_MM  (HYST_MM),
        .DEBOUNCE (DEBOUNCE)
      ) u_filt (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .valid   (valid[g]),
        .timeout (timeout[g]),
        .distance(distance_mm[g*DIST_W +: DIST_W]),
        .stop    (stop[g])
      );
    end
  endgenerate

  assign any_stop = |stop;

endmodule

// File: tb/tb_proximity_array.sv
// Directed bench for proximity_array with small timing parameters.
module tb_proximity_array;

  localparam int NUM_CH = 2;
  localparam int DIST_W = 8;

  logic        CLOCK_50 = 1'b0;
  logic        reset    = 1'b0;
  logic        enable   = 1'b0;
  logic [1:0]  echo     = 2'b00;
  logic [1:0]  trig;
  logic [15:0] distance_mm;
  logic [1:0]  valid;
  logic [1:0]  timeout;
  logic [1:0]  stop;
  logic        any_stop;
  logic [0:0]  active_ch;

  int tests = 0;
  int fails = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  proximity_array #(
    .NUM_CH(2), .DIST_W(8), .CYCLES_PER_MM(4), .TRIG_CYCLES(5),
    .WAIT_CYCLES(20), .GAP_CYCLES(10), .THRESH_MM(100), .HYST_MM(10),
    .DEBOUNCE(2)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .echo(echo),
    .trig(trig), .distance_mm(distance_mm), .valid(valid),
    .timeout(timeout), .stop(stop), .any_stop(any_stop),
    .active_ch(active_ch)
  );

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Waits for channel ch to trigger, optionally drives an echo of hi cycles
  // dly cycles after trig falls, and returns at the negedge where valid[ch]
  // is seen. lat is measured in cycles from the trig-fall negedge.
  task automatic run_ch(input int ch, input int hi, input int dly, input bit drop_en,
                        output logic [7:0] d, output logic to, output int lat,
                        output int tlen, output int other);
    int n;
    n = 0;
    other = 0;
    tlen = 0;
    d = 8'hxx;
    to = 1'bx;
    while (trig[ch] !== 1'b1 && n < 3000) begin @(negedge CLOCK_50); n++; end
    if (n >= 3000) begin
      tests++; fails++;
      $display("FAIL trig_start ch%0d: trig never rose within 3000 cycles", ch);
    end
    while (trig[ch] === 1'b1 && tlen < 100) begin
      if (trig[1-ch] !== 1'b0) other++;
      tlen++;
      @(negedge CLOCK_50);
    end
    repeat (dly) @(negedge CLOCK_50);
    if (hi > 0) begin
      echo[ch] = 1'b1;
      for (int i = 0; i < hi; i++) begin
        if (drop_en && i == hi / 2) enable = 1'b0;
        @(negedge CLOCK_50);
      end
      echo[ch] = 1'b0;
    end
    n = 0;
    while (valid[ch] !== 1'b1 && n < 2000) begin @(negedge CLOCK_50); n++; end
    if (n >= 2000) begin
      tests++; fails++;
      $display("FAIL valid_wait ch%0d: no valid within 2000 cycles", ch);
    end
    lat = dly + hi + n;
    d = distance_mm[ch*DIST_W +: DIST_W];
    to = timeout[ch];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLOCK_50);
    tests++;
    if ({trig, valid, timeout, stop, any_stop} !== 9'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b required 0", {trig, valid, timeout, stop, any_stop});
    end
    tests++;
    if (distance_mm !== 16'h0 || active_ch !== 1'b0) begin
      fails++;
      $display("FAIL reset_dist_ch: distance %h active_ch %0d required 0/0", distance_mm, active_ch);
    end
    reset = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    tests++;
    if (trig !== 2'b00) begin
      fails++;
      $display("FAIL idle_no_enable: trig %b required 00", trig);
    end
  endtask

  task automatic test_basic();
    logic [7:0] d; logic to; int lat, tl, ot;
    enable = 1'b1;
    run_ch(0, 200, 3, 1'b0, d, to, lat, tl, ot);
    tests++;
    if (tl !== 5) begin fails++; $display("FAIL trig_len: got %0d required 5", tl); end
    tests++;
    if (ot !== 0) begin fails++; $display("FAIL trig_other: trig[1] high %0d cycles required 0", ot); end
    tests++;
    if (d !== 8'd50 || to !== 1'b0) begin
      fails++; $display("FAIL basic_dist: got %0d to=%b required 50 to=0", d, to);
    end
    @(negedge CLOCK_50);
    tests++;
    if (valid !== 2'b00) begin fails++; $display("FAIL single_valid: valid %b required 00", valid); end
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic to; int lat, tl, ot;
    run_ch(1, 0, 0, 1'b0, d, to, lat, tl, ot);
    tests++;
    if (lat !== 20) begin fails++; $display("FAIL timeout_lat: got %0d required 20", lat); end
    tests++;
    if (to !== 1'b1 || d !== 8'd255) begin
      fails++; $display("FAIL timeout_dist: got %0d to=%b required 255 to=1", d, to);
    end
  endtask

  task automatic test_saturate();
    logic [7:0] d; logic to; int lat, tl, ot, n;
    n = 0;
    while (trig[0] !== 1'b1 && n < 3000) begin @(negedge CLOCK_50); n++; end
    while (trig[0] === 1'b1 && n < 3100) begin @(negedge CLOCK_50); n++; end
    repeat (3) @(negedge CLOCK_50);
    echo[0] = 1'b1;
    n = 0;
    while (valid[0] !== 1'b1 && n < 2000) begin @(negedge CLOCK_50); n++; end
    tests++;
    if (n < 1021 || n > 1025) begin
      fails++; $display("FAIL sat_time: got %0d cycles required 1021..1025", n);
    end
    tests++;
    if (distance_mm[7:0] !== 8'd255 || timeout[0] !== 1'b0) begin
      fails++; $display("FAIL sat_dist: got %0d to=%b required 255 to=0", distance_mm[7:0], timeout[0]);
    end
    run_ch(1, 0, 0, 1'b0, d, to, lat, tl, ot);
    run_ch(0, 0, 0, 1'b0, d, to, lat, tl, ot);
    tests++;
    if (to !== 1'b1 || d !== 8'd255 || lat !== 20) begin
      fails++; $display("FAIL stuck_high: got d=%0d to=%b lat=%0d required 255 1 20", d, to, lat);
    end
    echo[0] = 1'b0;
  endtask

  task automatic test_hysteresis();
    logic [7:0] d; logic to; int lat, tl, ot;
    int dv[5]  = '{80, 80, 105, 115, 115};
    bit  sb[5] = '{0, 0, 1, 1, 1};
    bit  sa[5] = '{0, 1, 1, 1, 0};
    for (int i = 0; i < 5; i++) begin
      run_ch(1, 0, 0, 1'b0, d, to, lat, tl, ot);
      run_ch(0, 4 * dv[i] + 3, 3, 1'b0, d, to, lat, tl, ot);
      tests++;
      if (d !== 8'(dv[i]) || stop[0] !== sb[i]) begin
        fails++; $display("FAIL hyst_at_valid[%0d]: d=%0d stop=%b required d=%0d stop=%b", i, d, stop[0], dv[i], sb[i]);
      end
      @(negedge CLOCK_50);
      tests++;
      if (stop[0] !== sa[i] || any_stop !== sa[i]) begin
        fails++; $display("FAIL hyst_after[%0d]: stop=%b any=%b required %b", i, stop[0], any_stop, sa[i]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] d; logic to; int lat, tl, ot, n;
    logic [0:0] nxt;
    run_ch(1, 0, 0, 1'b0, d, to, lat, tl, ot);
    for (int k = 0; k < 4; k++) begin
      run_ch(k % 2, 40, 3, (k == 3), d, to, lat, tl, ot);
      tests++;
      if (active_ch !== 1'(k % 2) || d !== 8'd10) begin
        fails++; $display("FAIL rr_result[%0d]: active_ch=%0d d=%0d required %0d 10", k, active_ch, d, k % 2);
      end
      n = 0;
      while (active_ch === 1'(k % 2) && n < 100) begin @(negedge CLOCK_50); n++; end
      nxt = active_ch;
      tests++;
      if (n !== 11 || nxt !== 1'((k + 1) % 2)) begin
        fails++; $display("FAIL rr_gap[%0d]: advanced after %0d to %0d required 11 to %0d", k, n, nxt, (k + 1) % 2);
      end
    end
    n = 0;
    repeat (40) begin @(negedge CLOCK_50); if (trig !== 2'b00) n++; end
    tests++;
    if (n !== 0) begin fails++; $display("FAIL idle_after_disable: trig high %0d cycles required 0", n); end
    tests++;
    if (stop !== 2'b11) begin fails++; $display("FAIL stop_both: got %b required 11", stop); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic to; int lat, tl, ot, n;
    enable = 1'b1;
    run_ch(0, 40, 3, 1'b0, d, to, lat, tl, ot);
    n = 0;
    while (trig[1] !== 1'b1 && n < 3000) begin @(negedge CLOCK_50); n++; end
    while (trig[1] === 1'b1 && n < 3100) begin @(negedge CLOCK_50); n++; end
    repeat (3) @(negedge CLOCK_50);
    echo[1] = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    #2 reset = 1'b0;
    #1;
    tests++;
    if ({trig, valid, stop, any_stop} !== 7'b0 || distance_mm !== 16'h0 || active_ch !== 1'b0) begin
      fails++; $display("FAIL reset_mid: trig=%b valid=%b stop=%b dist=%h ch=%0d required all 0",
                        trig, valid, stop, distance_mm, active_ch);
    end
    echo[1] = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    n = 0;
    while (trig === 2'b00 && n < 100) begin @(negedge CLOCK_50); n++; end
    tests++;
    if (trig !== 2'b01) begin fails++; $display("FAIL first_trig_after_reset: got %b required 01", trig); end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (trig !== 2'b00) begin fails++; $display("FAIL async_trig_drop: got %b required 00", trig); end
    enable = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_saturate();
    test_hysteresis();
    test_round_robin();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
